// File: rtl/alu_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_unit
// Description : Handshaked EX-stage unit: integer ALU ops in one cycle plus
//               iterative RV M-extension multiply/divide.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_c
);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [4:0] c_OP_ADD    = 5'd0;
    localparam logic [4:0] c_OP_SUB    = 5'd1;
    localparam logic [4:0] c_OP_AND    = 5'd2;
    localparam logic [4:0] c_OP_OR     = 5'd3;
    localparam logic [4:0] c_OP_XOR    = 5'd4;
    localparam logic [4:0] c_OP_SLL    = 5'd5;
    localparam logic [4:0] c_OP_SRL    = 5'd6;
    localparam logic [4:0] c_OP_SRA    = 5'd7;
    localparam logic [4:0] c_OP_SLT    = 5'd8;
    localparam logic [4:0] c_OP_SLTU   = 5'd9;
    localparam logic [4:0] c_OP_MUL    = 5'd10;
    localparam logic [4:0] c_OP_MULH   = 5'd11;
    localparam logic [4:0] c_OP_MULHSU = 5'd12;
    localparam logic [4:0] c_OP_MULHU  = 5'd13;
    localparam logic [4:0] c_OP_DIV    = 5'd14;
    localparam logic [4:0] c_OP_DIVU   = 5'd15;
    localparam logic [4:0] c_OP_REM    = 5'd16;
    localparam logic [4:0] c_OP_REMU   = 5'd17;

    localparam logic [SHW-1:0]  c_CNT_LAST = SHW'(XLEN - 1);
    localparam logic [SHW-1:0]  c_CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] c_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [1:0]        w_start_state;
    logic [4:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_prod;
    logic [SHW-1:0]    r_cnt;
    logic [XLEN-1:0]   r_alu_c;

    logic              w_accept;
    logic              w_iterating;
    logic              w_last_iter;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_div_iter;
    logic              w_quick;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg_in;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN-1:0]   w_quick_result;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod_next;
    logic [2*XLEN-1:0] w_mul_full;
    logic [XLEN-1:0]   w_div_mag;
    logic [XLEN-1:0]   w_div_fin;
    logic [XLEN-1:0]   w_iter_result;

    assign in_ready    = (r_state == c_ST_IDLE) | ((r_state == c_ST_DONE) & out_ready);
    assign out_valid   = (r_state == c_ST_DONE);
    assign alu_c       = r_alu_c;
    assign w_accept    = in_valid & in_ready & ~flush;
    assign w_iterating = ((r_state == c_ST_MUL) | (r_state == c_ST_DIV)) & ~flush;
    assign w_last_iter = (r_cnt == c_CNT_LAST);

    // Operand decode at acceptance: magnitudes and final result sign
    assign w_is_mul   = (alu_op >= c_OP_MUL) & (alu_op <= c_OP_MULHU);
    assign w_is_div   = (alu_op >= c_OP_DIV) & (alu_op <= c_OP_REMU);
    assign w_div_zero = (alu_b == '0);
    assign w_div_ovf  = ((alu_op == c_OP_DIV) | (alu_op == c_OP_REM)) &
                        (alu_a == c_MOST_NEG) & (alu_b == '1);
    assign w_div_iter = w_is_div & ~w_div_zero & ~w_div_ovf;
    assign w_quick    = ~w_is_mul & ~w_div_iter;
    assign w_a_neg    = alu_a[XLEN-1] & ((alu_op == c_OP_MULH) | (alu_op == c_OP_MULHSU) |
                                         (alu_op == c_OP_DIV)  | (alu_op == c_OP_REM));
    assign w_b_neg    = alu_b[XLEN-1] & ((alu_op == c_OP_MULH) | (alu_op == c_OP_DIV) |
                                         (alu_op == c_OP_REM));
    assign w_abs_a    = w_a_neg ? ('0 - alu_a) : alu_a;
    assign w_abs_b    = w_b_neg ? ('0 - alu_b) : alu_b;
    assign w_neg_in   = (alu_op == c_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_start_state = w_is_mul ? c_ST_MUL : (w_div_iter ? c_ST_DIV : c_ST_DONE);

    always_comb begin
        w_quick_result = '0;
        case (alu_op)
            c_OP_ADD:  w_quick_result = alu_a + alu_b;
            c_OP_SUB:  w_quick_result = alu_a - alu_b;
            c_OP_AND:  w_quick_result = alu_a & alu_b;
            c_OP_OR:   w_quick_result = alu_a | alu_b;
            c_OP_XOR:  w_quick_result = alu_a ^ alu_b;
            c_OP_SLL:  w_quick_result = alu_a << alu_b[SHW-1:0];
            c_OP_SRL:  w_quick_result = alu_a >> alu_b[SHW-1:0];
            c_OP_SRA:  w_quick_result = $unsigned($signed(alu_a) >>> alu_b[SHW-1:0]);
            c_OP_SLT:  w_quick_result = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            c_OP_SLTU: w_quick_result = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
            // Only the divide-by-zero and signed-overflow cases reach here
            c_OP_DIV, c_OP_DIVU: w_quick_result = w_div_zero ? '1 : alu_a;
            c_OP_REM, c_OP_REMU: w_quick_result = w_div_zero ? alu_a : '0;
            default:   w_quick_result = '0;
        endcase
    end

    // r_prod is {acc, multiplier} for multiply and {remainder, quotient} for divide
    assign w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
    assign w_shift = r_prod[2*XLEN-1:XLEN-1];
    assign w_diff  = w_shift - {1'b0, r_mcand};

    always_comb begin
        w_prod_next = {w_sum, r_prod[XLEN-1:1]};
        if (r_state == c_ST_DIV) begin
            if (w_diff[XLEN])
                w_prod_next = {w_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
            else
                w_prod_next = {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
        end
    end

    assign w_mul_full = r_neg ? ('0 - w_prod_next) : w_prod_next;
    assign w_div_mag  = ((r_op == c_OP_DIV) | (r_op == c_OP_DIVU)) ?
                        w_prod_next[XLEN-1:0] : w_prod_next[2*XLEN-1:XLEN];
    assign w_div_fin  = r_neg ? ('0 - w_div_mag) : w_div_mag;

    always_comb begin
        w_iter_result = w_div_fin;
        if (r_state == c_ST_MUL)
            w_iter_result = (r_op == c_OP_MUL) ? w_mul_full[XLEN-1:0] : w_mul_full[2*XLEN-1:XLEN];
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (w_accept) w_state_next = w_start_state;
                c_ST_MUL, c_ST_DIV: if (w_last_iter) w_state_next = c_ST_DONE;
                c_ST_DONE: begin
                    if (w_accept)
                        w_state_next = w_start_state;
                    else if (out_ready)
                        w_state_next = c_ST_IDLE;
                end
                default: w_state_next = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_op    <= '0;
            r_neg   <= 1'b0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_alu_c <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= alu_op;
                r_neg   <= w_neg_in;
                r_cnt   <= '0;
                r_mcand <= w_is_mul ? w_abs_a : w_abs_b;
                r_prod  <= {{XLEN{1'b0}}, (w_is_mul ? w_abs_b : w_abs_a)};
                if (w_quick)
                    r_alu_c <= w_quick_result;
            end else if (w_iterating) begin
                r_prod <= w_prod_next;
                r_cnt  <= r_cnt + c_CNT_ONE;
                if (w_last_iter)
                    r_alu_c <= w_iter_result;
            end
        end
    end

endmodule
`default_nettype wire
